// File: rtl/product_accumulator_pkg.sv
// Shared types and default sizing for the product accumulator.
// Holds the FSM state encoding and the width defaults used by the top.
package product_accumulator_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAcc  = 2'd1,
        StDone = 2'd2
    } acc_state_e;

    localparam int unsigned DefPw = 16;
    localparam int unsigned DefAw = 24;
    localparam int unsigned LenW  = 8;

endpackage

// File: rtl/product_accumulator.sv
// Sums a run of unsigned products into a wrapping accumulator with a sticky carry-out flag.
// Handshakes products in on in_valid/in_ready and the result out on out_valid/out_ready.
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int unsigned PW = DefPw,
    parameter int unsigned AW = DefAw
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [LenW-1:0] len,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [PW-1:0]   in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [AW-1:0]   sum,
    output logic            ovf,
    output logic            busy
);

    acc_state_e      r_state;
    logic [LenW-1:0] r_cnt;
    logic [AW-1:0]   r_sum;
    logic            r_ovf;
    logic            r_in_ready;
    logic            r_out_valid;
    logic            r_busy;

    logic            w_accept;
    logic [AW:0]     w_add;

    assign w_accept = in_valid & r_in_ready;
    // One extra bit on the adder captures the carry out of AW bits for ovf.
    assign w_add    = {1'b0, r_sum} + {{(AW + 1 - PW){1'b0}}, in_data};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_sum       <= '0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (start) begin
                        r_sum  <= '0;
                        r_ovf  <= 1'b0;
                        r_busy <= 1'b1;
                        if (len != '0) begin
                            r_cnt      <= len;
                            r_state    <= StAcc;
                            r_in_ready <= 1'b1;
                        end else begin
                            r_state     <= StDone;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                StAcc: begin
                    if (w_accept) begin
                        r_sum <= w_add[AW-1:0];
                        r_ovf <= r_ovf | w_add[AW];
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == LenW'(1)) begin
                            r_state     <= StDone;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        r_state     <= StIdle;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= StIdle;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign ovf       = r_ovf;
    assign busy      = r_busy;

endmodule
